key_seq_capture: RTL and testbench
==================================

# key_seq_capture

Pushbutton-driven entry block for the 4-digit sequence feature on the board top level. It synchronizes and debounces two active-low KEY inputs and samples the 4-bit switch value on each debounced "enter" press. It assembles four digits into a packed 16-bit sequence and holds it valid until the downstream checker/display logic acknowledges it. A "clear" press aborts entry.

## Interface
- P_DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); minimum 1
- P_DIGITS, 4, digits per sequence (fixed at 4 for this revision)
- P_DW, 4, bits per digit
- CLOCK_50  in  1  system clock, 50 MHz, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- KEY_ENTER_N  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50
- KEY_CLEAR_N  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50
- SW  in  4  digit value, sampled on accepted enter press
- SEQ_ACK  in  1  consumer acknowledge, one-cycle pulse, synchronous
- SEQ  out  16  captured digits, first entered in [15:12], last in [3:0]
- SEQ_COUNT  out  3  digits captured so far, 0..4
- SEQ_VALID  out  1  high while a complete 4-digit sequence is held
- ENTER_PULSE  out  1  one-cycle strobe per accepted enter press (LED/debug)

## Operation
- Each key has its own 2-flop synchronizer, then a debouncer holding a stable level (reset value 1 = released) and a counter.
- Debouncer: synchronized level equal to stable level -> counter cleared. Differing level -> counter increments. When counter reaches P_DEBOUNCE_CYCLES-1 and level still differs, the stable level takes the new value and the counter clears. Any bounce back clears the counter.
- Press event: stable level transitions 1->0. Release events generate nothing.
- FSM states:
  - EMPTY: SEQ_COUNT=0.
  - COLLECT: SEQ_COUNT 1..3.
  - FULL: SEQ_COUNT=4, SEQ_VALID=1.
- Enter press in EMPTY/COLLECT: SEQ <= {SEQ[11:0], SW}; SEQ_COUNT increments; ENTER_PULSE=1 for that cycle. At count 4 go to FULL.
- Enter press in FULL: ignored. No shift and no ENTER_PULSE.
- SEQ_ACK in FULL -> EMPTY, SEQ cleared to 0, SEQ_COUNT 0. SEQ_ACK in other states is ignored.
- Clear press in any state -> EMPTY, SEQ=0, SEQ_COUNT=0, SEQ_VALID=0.
- Simultaneous events in one cycle:
  - Clear beats enter and ack.
  - Ack beats enter in FULL, and that enter is dropped.
- RESET asserted mid-entry: all state is discarded immediately.

## Timing
- Reset values:
  - SEQ=16'h0000, SEQ_COUNT=0, SEQ_VALID=0, ENTER_PULSE=0.
  - FSM in EMPTY, both stable levels = 1, counters = 0, synchronizer flops = 1.
- Reset is asynchronous on assertion. Deassertion is synchronous to CLOCK_50 (externally guaranteed).
- Enter latency, with edge 1 being the first rising edge that samples KEY_ENTER_N low and the level held low throughout:
  - Synchronizer output low after edge 2.
  - Stable level changes at edge P_DEBOUNCE_CYCLES+2.
  - SEQ, SEQ_COUNT and ENTER_PULSE update at edge P_DEBOUNCE_CYCLES+3.
- SEQ_VALID rises on the same edge that SEQ_COUNT becomes 4. It falls on the edge that samples SEQ_ACK=1.
- Clear has the same latency as enter.
- A key held down produces exactly one press event. A new press requires a debounced release first.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use P_DEBOUNCE_CYCLES=4.

- Reset, then idle 20 cycles -> SEQ=0, SEQ_COUNT=0, SEQ_VALID=0, ENTER_PULSE never high.
- Clean presses with SW=1,2,3,4, each held 10 cycles:
  - SEQ_COUNT steps 1,2,3,4; SEQ=16'h1234; SEQ_VALID=1.
  - Each update lands exactly 7 edges after the low level is first sampled.
  - A fifth press with SW=9 leaves SEQ=16'h1234.
- Bounce: KEY_ENTER_N low 3 cycles, high 1, low 3, high -> no event.
  - Then hold low 6 cycles -> exactly one ENTER_PULSE.
- Two digits entered (SEQ=16'h0056), then a clear press -> SEQ=0, SEQ_COUNT=0.
  - Next entry of SW=A starts fresh: SEQ=16'h000A.
- FULL with SEQ=16'hBEEF:
  - SEQ_ACK pulse -> SEQ_VALID falls next edge, SEQ=0.
  - SEQ_ACK pulsed while SEQ_COUNT=2 -> no change.
- RESET asserted between edges mid-entry (SEQ_COUNT=3) -> outputs zero before the next clock edge.
  - A key held through reset release is treated as a new press after debounce.

Source files
------------

// File: rtl/key_seq_capture.sv
// Purpose: synchronize/debounce two active-low keys and assemble four SW digits into a held sequence.
// Latency: enter/clear act P_DEBOUNCE_CYCLES+3 edges after the first edge that samples the key low.
// Backpressure: a full sequence is held (later enters dropped) until SEQ_ACK; clear aborts at any time.
//
// Ports:
//   CLOCK_50, RESET          clock and asynchronous active-high reset
//   KEY_ENTER_N, KEY_CLEAR_N raw active-low pushbuttons, asynchronous to CLOCK_50
//   SW                       digit value captured on each accepted enter press
//   SEQ_ACK                  one-cycle consumer acknowledge, honoured only when full
//   SEQ, SEQ_COUNT           captured digits (first entered in the top nibble) and digit count
//   SEQ_VALID, ENTER_PULSE   full-sequence flag and one-cycle strobe per accepted digit

// Purpose: 2-flop synchronizer plus debouncer for one active-low key; emits a press strobe.
// Latency: press strobe registered on the edge the stable level falls (P_DEBOUNCE_CYCLES+2).
// Backpressure: none; a held key yields one strobe, releases yield nothing.
module key_debounce #(
    parameter int P_DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = (P_DEBOUNCE_CYCLES > 1) ? $clog2(P_DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(P_DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        sync_d   = {sync_q[0], key_n};
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        // Counter only runs while the synchronized level disagrees with the
        // stable one; any bounce back to agreement clears it via the default.
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                press_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;
endmodule

module key_seq_capture #(
    parameter int P_DEBOUNCE_CYCLES = 1000000,
    parameter int P_DIGITS          = 4,
    parameter int P_DW              = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic                     KEY_ENTER_N,
    input  logic                     KEY_CLEAR_N,
    input  logic [P_DW-1:0]          SW,
    input  logic                     SEQ_ACK,
    output logic [P_DIGITS*P_DW-1:0] SEQ,
    output logic [2:0]               SEQ_COUNT,
    output logic                     SEQ_VALID,
    output logic                     ENTER_PULSE
);
    localparam int SW_TOT = P_DIGITS * P_DW;
    localparam logic [2:0] CNT_LAST = 3'(P_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    logic enter_press;
    logic clear_press;

    state_t            state_q, state_d;
    logic [SW_TOT-1:0] seq_q, seq_d;
    logic [2:0]        count_q, count_d;
    logic              valid_q, valid_d;
    logic              pulse_q, pulse_d;

    key_debounce #(.P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)) u_enter (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (KEY_ENTER_N),
        .press (enter_press)
    );

    key_debounce #(.P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)) u_clear (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (KEY_CLEAR_N),
        .press (clear_press)
    );

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        count_d = count_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        // Clear has priority over everything, including a same-cycle enter or ack.
        if (clear_press) begin
            state_d = ST_EMPTY;
            seq_d   = '0;
            count_d = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY, ST_COLLECT: begin
                    if (enter_press) begin
                        seq_d   = {seq_q[SW_TOT-P_DW-1:0], SW};
                        count_d = count_q + 3'd1;
                        pulse_d = 1'b1;
                        if (count_q == CNT_LAST) begin
                            state_d = ST_FULL;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
                ST_FULL: begin
                    // Enter presses are dropped while full, even alongside an ack.
                    if (SEQ_ACK) begin
                        state_d = ST_EMPTY;
                        seq_d   = '0;
                        count_d = '0;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    seq_d   = '0;
                    count_d = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
            seq_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            count_q <= count_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    assign SEQ         = seq_q;
    assign SEQ_COUNT   = count_q;
    assign SEQ_VALID   = valid_q;
    assign ENTER_PULSE = pulse_q;
endmodule

// File: tb/tb_key_seq_capture.sv
// Purpose: directed self-checking bench for key_seq_capture with a 4-cycle debounce.
// Latency: digit updates expected exactly 7 edges after the key level is first sampled low.
// Backpressure: exercises full-hold, ack, ignored ack, clear abort and reset mid-entry.
module tb_key_seq_capture;
    logic        CLOCK_50;
    logic        RESET;
    logic        KEY_ENTER_N;
    logic        KEY_CLEAR_N;
    logic [3:0]  SW;
    logic        SEQ_ACK;
    logic [15:0] SEQ;
    logic [2:0]  SEQ_COUNT;
    logic        SEQ_VALID;
    logic        ENTER_PULSE;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;
    int pulse_mark  = 0;

    key_seq_capture #(
        .P_DEBOUNCE_CYCLES (4),
        .P_DIGITS          (4),
        .P_DW              (4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .KEY_ENTER_N (KEY_ENTER_N),
        .KEY_CLEAR_N (KEY_CLEAR_N),
        .SW          (SW),
        .SEQ_ACK     (SEQ_ACK),
        .SEQ         (SEQ),
        .SEQ_COUNT   (SEQ_COUNT),
        .SEQ_VALID   (SEQ_VALID),
        .ENTER_PULSE (ENTER_PULSE)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; tally every strobe seen.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (ENTER_PULSE === 1'b1) pulse_cnt++;
    endtask

    // Key is already low and edge 1 is the next edge: check the 7-edge landing,
    // hold to 10 cycles total, release and wait out the release debounce.
    task automatic finish_press(input string tag, input logic is_clear,
                                input logic [2:0] ecnt, input logic [15:0] eseq,
                                input logic epulse);
        repeat (6) tick();
        check({tag, " pulse@6"}, 16'(ENTER_PULSE), 16'd0);
        tick();
        check({tag, " pulse@7"}, 16'(ENTER_PULSE), 16'(epulse));
        check({tag, " count@7"}, 16'(SEQ_COUNT), 16'(ecnt));
        check({tag, " seq@7"}, SEQ, eseq);
        repeat (3) tick();
        if (is_clear) KEY_CLEAR_N = 1'b1;
        else          KEY_ENTER_N = 1'b1;
        repeat (8) tick();
    endtask

    task automatic do_enter(input string tag, input logic [3:0] sw,
                            input logic [2:0] ecnt, input logic [15:0] eseq,
                            input logic epulse);
        SW = sw;
        KEY_ENTER_N = 1'b0;
        finish_press(tag, 1'b0, ecnt, eseq, epulse);
    endtask

    task automatic do_clear(input string tag);
        KEY_CLEAR_N = 1'b0;
        finish_press(tag, 1'b1, 3'd0, 16'h0000, 1'b0);
    endtask

    task automatic ack_pulse();
        SEQ_ACK = 1'b1;
        tick();
        SEQ_ACK = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
        SW = 4'h0;
        SEQ_ACK = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;

        // Reset state and idle
        check("rst seq", SEQ, 16'h0000);
        check("rst count", 16'(SEQ_COUNT), 16'd0);
        check("rst valid", 16'(SEQ_VALID), 16'd0);
        check("rst pulse", 16'(ENTER_PULSE), 16'd0);
        pulse_mark = pulse_cnt;
        repeat (20) tick();
        check("idle seq", SEQ, 16'h0000);
        check("idle count", 16'(SEQ_COUNT), 16'd0);
        check("idle pulses", 16'(pulse_cnt - pulse_mark), 16'd0);

        // Four clean digits, then a fifth that must be ignored
        do_enter("d1", 4'h1, 3'd1, 16'h0001, 1'b1);
        check("d1 valid", 16'(SEQ_VALID), 16'd0);
        do_enter("d2", 4'h2, 3'd2, 16'h0012, 1'b1);
        do_enter("d3", 4'h3, 3'd3, 16'h0123, 1'b1);
        do_enter("d4", 4'h4, 3'd4, 16'h1234, 1'b1);
        check("d4 valid", 16'(SEQ_VALID), 16'd1);
        do_enter("d5", 4'h9, 3'd4, 16'h1234, 1'b0);
        check("d5 valid", 16'(SEQ_VALID), 16'd1);
        ack_pulse();
        check("ack1 valid", 16'(SEQ_VALID), 16'd0);
        check("ack1 seq", SEQ, 16'h0000);
        check("ack1 count", 16'(SEQ_COUNT), 16'd0);

        // Bounce: low 3, high 1, low 3, high -> nothing
        pulse_mark = pulse_cnt;
        SW = 4'h5;
        KEY_ENTER_N = 1'b0; repeat (3) tick();
        KEY_ENTER_N = 1'b1; tick();
        KEY_ENTER_N = 1'b0; repeat (3) tick();
        KEY_ENTER_N = 1'b1; repeat (12) tick();
        check("bounce pulses", 16'(pulse_cnt - pulse_mark), 16'd0);
        check("bounce count", 16'(SEQ_COUNT), 16'd0);
        // Then a 6-cycle hold gives exactly one event
        KEY_ENTER_N = 1'b0; repeat (6) tick();
        KEY_ENTER_N = 1'b1; repeat (12) tick();
        check("hold6 pulses", 16'(pulse_cnt - pulse_mark), 16'd1);
        check("hold6 seq", SEQ, 16'h0005);

        // Second digit, clear, fresh entry
        do_enter("d56", 4'h6, 3'd2, 16'h0056, 1'b1);
        do_clear("clr1");
        check("clr1 valid", 16'(SEQ_VALID), 16'd0);
        do_enter("fresh", 4'hA, 3'd1, 16'h000A, 1'b1);

        // Ack ignored at count 2, then fill BEEF and ack
        do_clear("clr2");
        do_enter("b", 4'hB, 3'd1, 16'h000B, 1'b1);
        do_enter("e1", 4'hE, 3'd2, 16'h00BE, 1'b1);
        ack_pulse();
        tick();
        check("ack2 count", 16'(SEQ_COUNT), 16'd2);
        check("ack2 seq", SEQ, 16'h00BE);
        do_enter("e2", 4'hE, 3'd3, 16'h0BEE, 1'b1);
        do_enter("f", 4'hF, 3'd4, 16'hBEEF, 1'b1);
        check("beef valid", 16'(SEQ_VALID), 16'd1);
        ack_pulse();
        check("ack3 valid", 16'(SEQ_VALID), 16'd0);
        check("ack3 seq", SEQ, 16'h0000);

        // Reset between edges at count 3, key held through reset release
        do_enter("r1", 4'h1, 3'd1, 16'h0001, 1'b1);
        do_enter("r2", 4'h2, 3'd2, 16'h0012, 1'b1);
        do_enter("r3", 4'h3, 3'd3, 16'h0123, 1'b1);
        SW = 4'h7;
        KEY_ENTER_N = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check("arst seq", SEQ, 16'h0000);
        check("arst count", 16'(SEQ_COUNT), 16'd0);
        check("arst valid", 16'(SEQ_VALID), 16'd0);
        tick();
        tick();
        RESET = 1'b0;
        finish_press("post-rst", 1'b0, 3'd1, 16'h0007, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
